// File: rtl/xext_bridge_pkg.sv
// Shared constants and state encoding for the external peripheral bus bridges.
package xext_bridge_pkg;

    localparam int unsigned EXT_ADDR_W  = 16;
    localparam int unsigned EXT_TIMEOUT = 255;
    localparam int unsigned CNT_W       = 8;

    typedef enum logic [1:0] {
        EXT_IDLE = 2'd0,
        EXT_REQ  = 2'd1,
        EXT_DONE = 2'd2
    } ext_state_t;

endpackage

// File: rtl/xtimeout_cnt.sv
// 8-bit clearable up-counter with a registered terminal-count flag at TIMEOUT-1.
module xtimeout_cnt
    import xext_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = EXT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register; tc is precomputed from the next count so it tracks cnt_q exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tc    <= (TC_VAL == '0);
        end else begin
            cnt_q <= cnt_d;
            tc    <= (cnt_d == TC_VAL);
        end
    end

endmodule

// File: rtl/xext_bridge.sv
// Turns a held ext_sel access into a req/ack transaction on the external bus,
// with a timeout that completes hung accesses as a bus error.
module xext_bridge #(
    parameter int unsigned EXT_ADDR_W = xext_bridge_pkg::EXT_ADDR_W,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TIMEOUT    = xext_bridge_pkg::EXT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ext_sel,
    input  logic [EXT_ADDR_W-1:0] addr,
    input  logic                  we,
    input  logic [DATA_W-1:0]     data_to_wr,
    output logic [DATA_W-1:0]     ext_data_to_rd,
    output logic                  ext_ready,
    output logic                  ext_err,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [EXT_ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_W-1:0]     bus_rdata
);

    import xext_bridge_pkg::*;

    ext_state_t state_q;
    ext_state_t state_d;

    logic                  cnt_clr;
    logic                  cnt_en;
    logic                  tc;

    logic                  bus_req_d;
    logic                  bus_we_d;
    logic [EXT_ADDR_W-1:0] bus_addr_d;
    logic [DATA_W-1:0]     bus_wdata_d;
    logic [DATA_W-1:0]     rd_data_d;
    logic                  ext_ready_d;
    logic                  ext_err_d;

    xtimeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EXT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: an ack on the terminal-count cycle still completes normally.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EXT_IDLE: if (ext_sel) state_d = EXT_REQ;
            EXT_REQ:  if (bus_ack || tc) state_d = EXT_DONE;
            EXT_DONE: state_d = EXT_IDLE;
            default:  state_d = EXT_IDLE;
        endcase
    end

    // Output and counter-control decode; every core-side output is registered below.
    always_comb begin
        bus_req_d   = (state_d == EXT_REQ);
        ext_ready_d = (state_d == EXT_DONE);
        ext_err_d   = 1'b0;
        bus_we_d    = bus_we;
        bus_addr_d  = bus_addr;
        bus_wdata_d = bus_wdata;
        rd_data_d   = ext_data_to_rd;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        unique case (state_q)
            EXT_IDLE: begin
                if (ext_sel) begin
                    bus_we_d    = we;
                    bus_addr_d  = addr;
                    bus_wdata_d = data_to_wr;
                    cnt_clr     = 1'b1;
                end
            end
            EXT_REQ: begin
                if (bus_ack) begin
                    if (!bus_we) begin
                        rd_data_d = bus_rdata;
                    end
                end else if (tc) begin
                    ext_err_d = 1'b1;
                    rd_data_d = '0;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Output registers; reset drops bus_req asynchronously to abort an in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req        <= 1'b0;
            bus_we         <= 1'b0;
            bus_addr       <= '0;
            bus_wdata      <= '0;
            ext_data_to_rd <= '0;
            ext_ready      <= 1'b0;
            ext_err        <= 1'b0;
        end else begin
            bus_req        <= bus_req_d;
            bus_we         <= bus_we_d;
            bus_addr       <= bus_addr_d;
            bus_wdata      <= bus_wdata_d;
            ext_data_to_rd <= rd_data_d;
            ext_ready      <= ext_ready_d;
            ext_err        <= ext_err_d;
        end
    end

endmodule

// File: tb/tb_xext_bridge.sv
// Scoreboard bench for xext_bridge: the driver pushes the expected completion of
// each access, a negedge monitor pops and compares whatever the DUT presents.
module tb_xext_bridge;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ext_sel = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          we = 1'b0;
    logic [DW-1:0] data_to_wr = '0;
    logic [DW-1:0] ext_data_to_rd;
    logic          ext_ready;
    logic          ext_err;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack = 1'b0;
    logic [DW-1:0] bus_rdata = '0;

    typedef struct {
        int            start;
        int            ready;
        logic          err;
        logic [DW-1:0] rd;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } exp_t;

    exp_t          q[$];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] model_rd = '0;
    logic [DW-1:0] last_rd = '0;

    xext_bridge #(
        .EXT_ADDR_W (AW),
        .DATA_W     (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ext_sel        (ext_sel),
        .addr           (addr),
        .we             (we),
        .data_to_wr     (data_to_wr),
        .ext_data_to_rd (ext_data_to_rd),
        .ext_ready      (ext_ready),
        .ext_err        (ext_err),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_ack        (bus_ack),
        .bus_rdata      (bus_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: bus_req window, bus fields, completion timing/status and held read data.
    always @(negedge clk) begin
        if (rst_n) begin
            bit exp_req;
            exp_req = (q.size() > 0) && (cyc > q[0].start) && (cyc < q[0].ready);
            chk("bus_req", DW'(bus_req), DW'(exp_req));
            if (bus_req && exp_req) begin
                chk("bus_we", DW'(bus_we), DW'(q[0].we));
                chk("bus_addr", DW'(bus_addr), DW'(q[0].addr));
                chk("bus_wdata", bus_wdata, q[0].wd);
            end
            if ((q.size() > 0) && (cyc == q[0].ready)) begin
                chk("ext_ready", DW'(ext_ready), DW'(1));
                chk("ext_err", DW'(ext_err), DW'(q[0].err));
                last_rd = q[0].rd;
                void'(q.pop_front());
            end else begin
                chk("ext_ready_quiet", DW'(ext_ready), DW'(0));
                chk("ext_err_quiet", DW'(ext_err), DW'(0));
            end
            chk("ext_data_to_rd", ext_data_to_rd, last_rd);
        end
    end

    // Present an access and record its expected completion. k = ack cycle (1-based).
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int k, input logic [DW-1:0] rd, input bit b2b, output int c0);
        exp_t e;
        c0 = b2b ? cyc + 1 : cyc;
        ext_sel    = 1'b1;
        we         = w;
        addr       = a;
        data_to_wr = wd;
        e.start = c0;
        e.we    = w;
        e.addr  = a;
        e.wd    = wd;
        if (k >= 1 && k <= int'(TO)) begin
            e.ready = c0 + k + 1;
            e.err   = 1'b0;
            if (!w) model_rd = rd;
        end else begin
            e.ready  = c0 + int'(TO) + 1;
            e.err    = 1'b1;
            model_rd = '0;
        end
        e.rd = model_rd;
        q.push_back(e);
    endtask

    // Play the external responder until ext_ready shows up (bounded).
    task automatic complete(input int c0, input int k, input logic [DW-1:0] rd);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk); #1;
            bus_ack = 1'b0;
            if (ext_ready) begin
                done = 1'b1;
            end else if (cyc == c0 + k) begin
                bus_ack   = 1'b1;
                bus_rdata = rd;
            end else begin
                bus_rdata = $urandom;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_ready: ext_ready got 0 expected 1 within 40 cycles (cycle %0d)", cyc);
        end
    endtask

    // One full access; leaves a random stray ack in the DONE cycle.
    task automatic do_acc(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int k, input logic [DW-1:0] rd, input bit b2b);
        int c0;
        if (!b2b) begin
            @(negedge clk); #1;
            bus_ack = 1'b0;
        end
        issue(w, a, wd, k, rd, b2b, c0);
        complete(c0, k, rd);
        ext_sel   = 1'b0;
        bus_ack   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
    endtask

    // Idle cycles with random stray acks.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            bus_ack   = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
        end
    endtask

    initial begin
        int c0;
        repeat (3) @(negedge clk);
        chk("rst_bus_req", DW'(bus_req), DW'(0));
        chk("rst_bus_we", DW'(bus_we), DW'(0));
        chk("rst_bus_addr", DW'(bus_addr), DW'(0));
        chk("rst_bus_wdata", bus_wdata, DW'(0));
        chk("rst_rd", ext_data_to_rd, DW'(0));
        chk("rst_ready", DW'(ext_ready), DW'(0));
        chk("rst_err", DW'(ext_err), DW'(0));
        #1 rst_n = 1'b1;

        do_acc(1'b0, 16'h0010, 32'h0, 3, 32'hA5A5_1234, 1'b0);
        do_acc(1'b1, 16'h0020, 32'hCAFE_F00D, 1, 32'h1111_2222, 1'b0);
        do_acc(1'b0, 16'h0030, 32'h0, 0, 32'h3333_4444, 1'b0);
        do_acc(1'b0, 16'h0040, 32'h0, int'(TO), 32'h5A5A_0F0F, 1'b0);

        // Abort an access with reset while bus_req is high.
        @(negedge clk); #1;
        bus_ack = 1'b0;
        issue(1'b0, 16'h0050, 32'h0, 0, 32'h0, 1'b0, c0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_bus_req", DW'(bus_req), DW'(0));
        chk("abort_ready", DW'(ext_ready), DW'(0));
        q.delete();
        model_rd = '0;
        last_rd  = '0;
        ext_sel  = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        do_acc(1'b0, 16'h0060, 32'h0, 2, 32'h600D_BEEF, 1'b0);
        idle(4);
        do_acc(1'b0, 16'h0070, 32'h0, 1, 32'h0707_0707, 1'b0);
        do_acc(1'b0, 16'h0071, 32'h0, 2, 32'h7171_7171, 1'b1);

        for (int i = 0; i < 40; i++) begin
            bit b2b;
            b2b = ($urandom_range(0, 3) == 0);
            if (!b2b) idle($urandom_range(0, 2));
            do_acc(1'($urandom_range(0, 1)), AW'($urandom), $urandom,
                   $urandom_range(0, 5), $urandom, b2b);
        end

        idle(6);
        bus_ack = 1'b0;
        chk("pending_left", DW'(q.size()), DW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
